mac_seq: RTL and testbench

//  Job sequencer that drives the 8x8->20-bit mac accumulator block.

---
 rtl/mac_seq.sv | 183 ++++++++++++++++++
 tb/tb_mac_seq.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_seq.sv
// -----------------------------------------------------------------------------
// mac_seq
//
// Job sequencer in front of the 8x8->20-bit mac accumulator. A job:
//   1. clears the mac with a one-cycle sclr pulse,
//   2. streams VEC_LEN operand pairs into it (bubbles feed zeros),
//   3. waits out the mac's two pipeline stages,
//   4. then presents the dot product on a valid/ready result port.
//
// This block is the only driver of the mac's i_a/i_b/sclr, and those are
// registered here.
//
// Parameters
//   VEC_LEN  operand pairs per job, 1..16. The maximum sum is
//            16*255*255 = 1040400, which fits in 20 bits.
//
// Ports
//   clk      clock
//   rst      synchronous reset, active high
//   s_valid  operand pair valid
//   s_ready  pair accepted on this cycle's edge (FEED only)
//   s_a      operand a, unsigned
//   s_b      operand b, unsigned
//   m_a      to mac i_a, registered
//   m_b      to mac i_b, registered
//   m_sclr   to mac sclr, registered, high only in CLR
//   m_mac    from mac o_mac
//   r_valid  result valid, held until r_ready
//   r_ready  result consumer ready
//   r_data   dot-product result
//   busy     high in every state except IDLE
// -----------------------------------------------------------------------------
module mac_seq #(
  parameter int unsigned VEC_LEN = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [7:0]  s_a,
  input  logic [7:0]  s_b,
  output logic [7:0]  m_a,
  output logic [7:0]  m_b,
  output logic        m_sclr,
  input  logic [19:0] m_mac,
  output logic        r_valid,
  input  logic        r_ready,
  output logic [19:0] r_data,
  output logic        busy
);

  // Out-of-range lengths are rejected when the design is elaborated.
  generate
    if (VEC_LEN < 1 || VEC_LEN > 16) begin : g_bad_vec_len
      $error("mac_seq: VEC_LEN must be in 1..16");
    end
  endgenerate

  localparam int CNT_W = 5;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(VEC_LEN - 1);

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    FEED,
    DRAIN,
    DONE
  } state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [1:0]        drain_q;
  logic              s_ready_q;
  logic [7:0]        m_a_q;
  logic [7:0]        m_b_q;
  logic              m_sclr_q;
  logic              r_valid_q;
  logic [19:0]       r_data_q;
  logic              busy_q;

  logic              accept;

  // s_ready is a register, so a transfer is decided entirely by what is
  // visible to the source during the cycle.
  assign accept = s_valid & s_ready_q;

  // Single FSM process; every output is a register updated together with
  // the state so outputs always match the state they belong to.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      drain_q   <= '0;
      s_ready_q <= 1'b0;
      m_a_q     <= '0;
      m_b_q     <= '0;
      m_sclr_q  <= 1'b0;
      r_valid_q <= 1'b0;
      r_data_q  <= '0;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          m_a_q <= '0;
          m_b_q <= '0;
          // A pending pair only starts the job; it is consumed later in FEED.
          if (s_valid) begin
            state_q  <= CLR;
            m_sclr_q <= 1'b1;
            busy_q   <= 1'b1;
          end
        end

        CLR: begin
          // The mac clears at the edge that leaves this state.
          state_q   <= FEED;
          m_sclr_q  <= 1'b0;
          cnt_q     <= '0;
          s_ready_q <= 1'b1;
          m_a_q     <= '0;
          m_b_q     <= '0;
        end

        FEED: begin
          if (accept) begin
            m_a_q <= s_a;
            m_b_q <= s_b;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == LAST_IDX) begin
              state_q   <= DRAIN;
              s_ready_q <= 1'b0;
              drain_q   <= '0;
            end
          end else begin
            // Bubble: zero operands add nothing to the running sum.
            m_a_q <= '0;
            m_b_q <= '0;
          end
        end

        DRAIN: begin
          // drain_q 0: m_a/m_b carry the last pair
          // drain_q 1: mac product register holds the last product
          // drain_q 2: m_mac holds the complete sum
          m_a_q   <= '0;
          m_b_q   <= '0;
          drain_q <= drain_q + 2'd1;
          if (drain_q == 2'd2) begin
            r_data_q  <= m_mac;
            r_valid_q <= 1'b1;
            state_q   <= DONE;
          end
        end

        DONE: begin
          // r_data stays frozen until the consumer takes it.
          if (r_ready) begin
            r_valid_q <= 1'b0;
            busy_q    <= 1'b0;
            state_q   <= IDLE;
          end
        end

        default: begin
          state_q   <= IDLE;
          s_ready_q <= 1'b0;
          m_sclr_q  <= 1'b0;
          r_valid_q <= 1'b0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign s_ready = s_ready_q;
  assign m_a     = m_a_q;
  assign m_b     = m_b_q;
  assign m_sclr  = m_sclr_q;
  assign r_valid = r_valid_q;
  assign r_data  = r_data_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_mac_seq.sv
// -----------------------------------------------------------------------------
// tb_mac_seq
//
// Two sequencers (VEC_LEN=4 and VEC_LEN=16) each drive a behavioural model
// of the 2-stage mac (mul <= a*b; psum <= psum + mul; sclr clears both;
// reset via rst_n = ~rst). Each job's expected result is the plain dot
// product of the pairs the bench handed over.
// -----------------------------------------------------------------------------
module tb_mac_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- VEC_LEN = 4 instance ----------------
  logic        rst4, s_valid4, s_ready4, m_sclr4, r_valid4, r_ready4, busy4;
  logic [7:0]  s_a4, s_b4, m_a4, m_b4;
  logic [19:0] m_mac4, r_data4;

  mac_seq #(.VEC_LEN(4)) u4 (
    .clk(clk), .rst(rst4),
    .s_valid(s_valid4), .s_ready(s_ready4), .s_a(s_a4), .s_b(s_b4),
    .m_a(m_a4), .m_b(m_b4), .m_sclr(m_sclr4), .m_mac(m_mac4),
    .r_valid(r_valid4), .r_ready(r_ready4), .r_data(r_data4), .busy(busy4)
  );

  // ---------------- VEC_LEN = 16 instance ----------------
  logic        rst16, s_valid16, s_ready16, m_sclr16, r_valid16, r_ready16, busy16;
  logic [7:0]  s_a16, s_b16, m_a16, m_b16;
  logic [19:0] m_mac16, r_data16;

  mac_seq #(.VEC_LEN(16)) u16 (
    .clk(clk), .rst(rst16),
    .s_valid(s_valid16), .s_ready(s_ready16), .s_a(s_a16), .s_b(s_b16),
    .m_a(m_a16), .m_b(m_b16), .m_sclr(m_sclr16), .m_mac(m_mac16),
    .r_valid(r_valid16), .r_ready(r_ready16), .r_data(r_data16), .busy(busy16)
  );

  // ---------------- mac models ----------------
  logic        rst_n4, rst_n16;
  logic [15:0] mul4, mul16;
  logic [19:0] psum4, psum16;
  assign rst_n4  = ~rst4;
  assign rst_n16 = ~rst16;

  always_ff @(posedge clk) begin
    if (!rst_n4 || m_sclr4) begin
      mul4  <= '0;
      psum4 <= '0;
    end else begin
      mul4  <= m_a4 * m_b4;
      psum4 <= psum4 + 20'(mul4);
    end
  end
  assign m_mac4 = psum4;

  always_ff @(posedge clk) begin
    if (!rst_n16 || m_sclr16) begin
      mul16  <= '0;
      psum16 <= '0;
    end else begin
      mul16  <= m_a16 * m_b16;
      psum16 <= psum16 + 20'(mul16);
    end
  end
  assign m_mac16 = psum16;

  // Job operands, filled by each test before starting a job.
  logic [7:0] job_a [16];
  logic [7:0] job_b [16];

  // ---------------- job driver for VEC_LEN = 4 ----------------
  // gap < 0 means a random 0..3 idle cycles after each accepted pair.
  task automatic run_job4(input int gap, input int hold, input string name);
    int          sum = 0;
    logic [19:0] expv;
    int          idx = 0, gap_left = 0, sclr_cnt = 0, cyc = 0, lat = 0;
    bit          acc, first = 1'b1;
    for (int i = 0; i < 4; i++) sum += int'(job_a[i]) * int'(job_b[i]);
    expv = 20'(sum);

    while (idx < 4 && cyc < 400) begin
      if (gap_left > 0) begin
        s_valid4 = 1'b0;
        s_a4 = 8'($urandom);
        s_b4 = 8'($urandom);
        gap_left--;
      end else begin
        s_valid4 = 1'b1;
        s_a4 = job_a[idx];
        s_b4 = job_b[idx];
      end
      r_ready4 = 1'($urandom_range(0, 1));
      acc = s_valid4 && s_ready4;
      @(posedge clk); #1;
      cyc++;
      if (m_sclr4) sclr_cnt++;
      if (first) begin
        first = 1'b0;
        checks++;
        if (m_sclr4 !== 1'b1 || busy4 !== 1'b1) begin
          errors++;
          $display("FAIL %s start: m_sclr=%0b busy=%0b, required 1 1 one edge after IDLE", name, m_sclr4, busy4);
        end
      end
      checks++;
      if (acc) begin
        if (m_a4 !== job_a[idx] || m_b4 !== job_b[idx]) begin
          errors++;
          $display("FAIL %s feed[%0d]: m_a=%0d m_b=%0d, required %0d %0d", name, idx, m_a4, m_b4, job_a[idx], job_b[idx]);
        end
        idx++;
        gap_left = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
      end else if (m_a4 !== 8'd0 || m_b4 !== 8'd0) begin
        errors++;
        $display("FAIL %s bubble: m_a=%0d m_b=%0d, required 0 0", name, m_a4, m_b4);
      end
    end
    s_valid4 = 1'b0;
    if (idx < 4) begin
      checks++;
      errors++;
      $display("FAIL %s feed timeout: accepted %0d pairs, required 4", name, idx);
      return;
    end

    while (!r_valid4 && lat < 10) begin
      r_ready4 = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      lat++;
      if (m_sclr4) sclr_cnt++;
    end
    checks++;
    if (lat !== 3) begin
      errors++;
      $display("FAIL %s latency: r_valid after %0d edges, required 3", name, lat);
    end
    checks++;
    if (r_data4 !== expv) begin
      errors++;
      $display("FAIL %s result: r_data=%0d, required %0d", name, r_data4, expv);
    end
    checks++;
    if (sclr_cnt !== 1) begin
      errors++;
      $display("FAIL %s sclr pulses: %0d, required 1", name, sclr_cnt);
    end

    // Stall the consumer while a new pair waits at the source.
    r_ready4 = 1'b0;
    s_valid4 = 1'b1;
    s_a4 = 8'($urandom);
    s_b4 = 8'($urandom);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      checks++;
      if (r_valid4 !== 1'b1 || r_data4 !== expv || s_ready4 !== 1'b0 || m_sclr4 !== 1'b0) begin
        errors++;
        $display("FAIL %s hold[%0d]: r_valid=%0b r_data=%0d s_ready=%0b m_sclr=%0b, required 1 %0d 0 0",
                 name, h, r_valid4, r_data4, s_ready4, m_sclr4, expv);
      end
    end
    r_ready4 = 1'b1;
    s_valid4 = 1'b0;
    @(posedge clk); #1;
    r_ready4 = 1'b0;
    checks++;
    if (r_valid4 !== 1'b0 || busy4 !== 1'b0) begin
      errors++;
      $display("FAIL %s handshake: r_valid=%0b busy=%0b, required 0 0", name, r_valid4, busy4);
    end
    $display("job %s: result %0d expected %0d latency %0d", name, r_data4, expv, lat);
  endtask

  // ---------------- job driver for VEC_LEN = 16 ----------------
  task automatic run_job16(input string name);
    int          sum = 0;
    logic [19:0] expv;
    int          idx = 0, cyc = 0, lat = 0, sclr_cnt = 0;
    bit          acc;
    for (int i = 0; i < 16; i++) sum += int'(job_a[i]) * int'(job_b[i]);
    expv = 20'(sum);
    while (idx < 16 && cyc < 400) begin
      s_valid16 = 1'b1;
      s_a16 = job_a[idx];
      s_b16 = job_b[idx];
      acc = s_valid16 && s_ready16;
      @(posedge clk); #1;
      cyc++;
      if (m_sclr16) sclr_cnt++;
      if (acc) idx++;
    end
    s_valid16 = 1'b0;
    if (idx < 16) begin
      checks++;
      errors++;
      $display("FAIL %s feed timeout: accepted %0d pairs, required 16", name, idx);
      return;
    end
    while (!r_valid16 && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (lat !== 3 || r_data16 !== expv || sclr_cnt !== 1) begin
      errors++;
      $display("FAIL %s result: r_data=%0d latency=%0d sclr=%0d, required %0d 3 1", name, r_data16, lat, sclr_cnt, expv);
    end
    r_ready16 = 1'b1;
    @(posedge clk); #1;
    r_ready16 = 1'b0;
    checks++;
    if (r_valid16 !== 1'b0 || busy16 !== 1'b0) begin
      errors++;
      $display("FAIL %s handshake: r_valid=%0b busy=%0b, required 0 0", name, r_valid16, busy16);
    end
    $display("job %s: result %0d expected %0d latency %0d", name, r_data16, expv, lat);
  endtask

  // ---------------- tests ----------------
  task automatic check_reset4(input string name);
    checks++;
    if (s_ready4 !== 1'b0 || m_a4 !== 8'd0 || m_b4 !== 8'd0 || m_sclr4 !== 1'b0 ||
        r_valid4 !== 1'b0 || r_data4 !== 20'd0 || busy4 !== 1'b0) begin
      errors++;
      $display("FAIL %s: s_ready=%0b m_a=%0d m_b=%0d m_sclr=%0b r_valid=%0b r_data=%0d busy=%0b, required all 0",
               name, s_ready4, m_a4, m_b4, m_sclr4, r_valid4, r_data4, busy4);
    end
  endtask

  task automatic test_reset();
    rst4 = 1'b1; rst16 = 1'b1;
    s_valid4 = 1'b1; s_a4 = 8'd9; s_b4 = 8'd9; r_ready4 = 1'b0;
    s_valid16 = 1'b0; s_a16 = 8'd0; s_b16 = 8'd0; r_ready16 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset4("reset4");
    checks++;
    if (s_ready16 !== 1'b0 || m_a16 !== 8'd0 || m_sclr16 !== 1'b0 || r_valid16 !== 1'b0 ||
        r_data16 !== 20'd0 || busy16 !== 1'b0) begin
      errors++;
      $display("FAIL reset16: s_ready=%0b m_a=%0d m_sclr=%0b r_valid=%0b r_data=%0d busy=%0b, required all 0",
               s_ready16, m_a16, m_sclr16, r_valid16, r_data16, busy16);
    end
    s_valid4 = 1'b0;
    rst4 = 1'b0; rst16 = 1'b0;
    @(posedge clk); #1;
    $display("reset: done");
  endtask

  task automatic test_basic();
    for (int i = 0; i < 4; i++) begin
      job_a[i] = 8'(2 * i + 1);
      job_b[i] = 8'(2 * i + 2);
    end
    run_job4(0, 0, "basic");
  endtask

  task automatic test_full_scale();
    for (int i = 0; i < 16; i++) begin
      job_a[i] = 8'd255;
      job_b[i] = 8'd255;
    end
    run_job16("full_scale");
  endtask

  task automatic test_stall();
    for (int i = 0; i < 4; i++) begin
      job_a[i] = 8'(2 * i + 1);
      job_b[i] = 8'(2 * i + 2);
    end
    run_job4(2, 0, "stall");
  endtask

  task automatic test_hold();
    for (int i = 0; i < 4; i++) begin
      job_a[i] = 8'($urandom);
      job_b[i] = 8'($urandom);
    end
    run_job4(0, 10, "hold");
  endtask

  task automatic test_mid_reset();
    int  accepted = 0, cyc = 0;
    bit  acc;
    while (accepted < 2 && cyc < 50) begin
      s_valid4 = 1'b1;
      s_a4 = 8'($urandom);
      s_b4 = 8'($urandom);
      acc = s_valid4 && s_ready4;
      @(posedge clk); #1;
      cyc++;
      if (acc) accepted++;
    end
    checks++;
    if (accepted != 2) begin
      errors++;
      $display("FAIL mid_reset prefix: accepted %0d pairs, required 2", accepted);
    end
    rst4 = 1'b1;
    @(posedge clk); #1;
    check_reset4("mid_reset");
    rst4 = 1'b0;
    s_valid4 = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      job_a[i] = 8'd2;
      job_b[i] = 8'd3;
    end
    run_job4(0, 0, "after_reset");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      job_a[i] = 8'd1;
      job_b[i] = 8'd1;
    end
    run_job4(0, 0, "b2b_first");
    for (int i = 0; i < 4; i++) begin
      job_a[i] = 8'd2;
      job_b[i] = 8'd2;
    end
    run_job4(0, 0, "b2b_second");
  endtask

  task automatic test_random();
    for (int j = 0; j < 25; j++) begin
      for (int i = 0; i < 4; i++) begin
        job_a[i] = 8'($urandom);
        job_b[i] = 8'($urandom);
      end
      run_job4(-1, int'($urandom_range(0, 3)), $sformatf("rand4_%0d", j));
    end
    for (int j = 0; j < 4; j++) begin
      for (int i = 0; i < 16; i++) begin
        job_a[i] = 8'($urandom);
        job_b[i] = 8'($urandom);
      end
      run_job16($sformatf("rand16_%0d", j));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full_scale();
    test_stall();
    test_hold();
    test_mid_reset();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
